xy_route_queue: RTL and testbench

- Per-input-port route-computation stage for the VC-based mesh router. It sits directly upstream of the port-select correction logic.
- On each header flit it computes the deterministic XY output port from the destination address, and queues that port per VC.
- It presents the head-of-queue port number (full PORT_NUM encoding, including own port) to the switch/VC allocators until the packet's tail flit leaves the router.

---
 rtl/xy_route_queue_if.sv | 40 ++++
 rtl/xy_route_queue.sv | 157 +++++++++++++++
 tb/tb_xy_route_queue.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/xy_route_queue_if.sv
// ---------------------------------------------------------------------------
// xy_route_queue_if
// Bundle between an input-port buffer / allocator pair and the XY
// route-computation queue.
//   hdr_wr       header flit written this cycle
//   hdr_vc       one-hot VC of that header
//   dest_x/y     destination coordinates taken from the header flit
//   tail_sent    per-VC pulse: tail flit of the head packet left the router
//   port_num_bcd per-VC head-of-queue output port, VC i at [i*PW +: PW]
//   route_valid  per-VC queue non-empty
//   queue_full   per-VC queue full
//   route_err    sticky error flag
// master = flit buffer / allocator side, slave = route queue.
// ---------------------------------------------------------------------------
interface xy_route_queue_if #(
  parameter int V  = 4,
  parameter int XW = 2,
  parameter int YW = 2,
  parameter int PW = 3
);
  logic            hdr_wr;
  logic [V-1:0]    hdr_vc;
  logic [XW-1:0]   dest_x;
  logic [YW-1:0]   dest_y;
  logic [V-1:0]    tail_sent;
  logic [V*PW-1:0] port_num_bcd;
  logic [V-1:0]    route_valid;
  logic [V-1:0]    queue_full;
  logic            route_err;

  modport master (
    output hdr_wr, hdr_vc, dest_x, dest_y, tail_sent,
    input  port_num_bcd, route_valid, queue_full, route_err
  );

  modport slave (
    input  hdr_wr, hdr_vc, dest_x, dest_y, tail_sent,
    output port_num_bcd, route_valid, queue_full, route_err
  );
endinterface

// File: rtl/xy_route_queue.sv
// ---------------------------------------------------------------------------
// xy_route_queue
// Per-input-port route computation for the VC mesh router. Each header flit
// gets its deterministic XY output port (0=local 1=east 2=north 3=west
// 4=south), which is queued per VC. The head entry of each VC is presented
// to the allocators until the packet's tail flit leaves the router.
// Ports:
//   clk    router clock
//   reset  asynchronous active-low reset
//   rq     xy_route_queue_if.slave (header/tail inputs, per-VC route outputs)
// All outputs come straight from flops.
// ---------------------------------------------------------------------------
module xy_route_queue #(
  parameter int V           = 4,
  parameter int X_NODE_NUM  = 4,
  parameter int Y_NODE_NUM  = 4,
  parameter int SW_X_ADDR   = 0,
  parameter int SW_Y_ADDR   = 0,
  parameter int PORT_NUM    = 5,
  parameter int QUEUE_DEPTH = 2,
  parameter int XW          = $clog2(X_NODE_NUM),
  parameter int YW          = $clog2(Y_NODE_NUM),
  parameter int PW          = $clog2(PORT_NUM)
) (
  input logic             clk,
  input logic             reset,
  xy_route_queue_if.slave rq
);

  localparam int PTRW = $clog2(QUEUE_DEPTH);
  localparam int CW   = $clog2(QUEUE_DEPTH + 1);

  localparam logic [PW-1:0] P_LOCAL = PW'(0);
  localparam logic [PW-1:0] P_EAST  = PW'(1);
  localparam logic [PW-1:0] P_NORTH = PW'(2);
  localparam logic [PW-1:0] P_WEST  = PW'(3);
  localparam logic [PW-1:0] P_SOUTH = PW'(4);

  // Destination outside the mesh; compared at 32 bits so widths wider than
  // the mesh still detect it.
  function automatic logic out_of_range(input logic [XW-1:0] dx, input logic [YW-1:0] dy);
    return (32'(dx) >= 32'(X_NODE_NUM)) || (32'(dy) >= 32'(Y_NODE_NUM));
  endfunction

  // Dimension-ordered XY route: resolve x first, then y; north is lower y.
  function automatic logic [PW-1:0] xy_route(input logic [XW-1:0] dx, input logic [YW-1:0] dy);
    logic [PW-1:0] p;
    if (out_of_range(dx, dy))               p = P_LOCAL;
    else if (32'(dx) > 32'(SW_X_ADDR))      p = P_EAST;
    else if (32'(dx) < 32'(SW_X_ADDR))      p = P_WEST;
    else if (32'(dy) < 32'(SW_Y_ADDR))      p = P_NORTH;
    else if (32'(dy) > 32'(SW_Y_ADDR))      p = P_SOUTH;
    else                                    p = P_LOCAL;
    return p;
  endfunction

  function automatic logic is_onehot(input logic [V-1:0] v);
    return (v != {V{1'b0}}) && ((v & (v - V'(1))) == {V{1'b0}});
  endfunction

  logic [PW-1:0]   mem_r      [V][QUEUE_DEPTH];
  logic [PTRW-1:0] rd_r       [V];
  logic [PTRW-1:0] wr_r       [V];
  logic [CW-1:0]   cnt_r      [V];
  logic [V*PW-1:0] port_r;
  logic [V-1:0]    valid_r;
  logic [V-1:0]    full_r;
  logic            err_r;

  logic [PW-1:0]   mem_nxt_s  [V][QUEUE_DEPTH];
  logic [PTRW-1:0] rd_nxt_s   [V];
  logic [PTRW-1:0] wr_nxt_s   [V];
  logic [CW-1:0]   cnt_nxt_s  [V];
  logic [V*PW-1:0] port_nxt_s;
  logic [V-1:0]    valid_nxt_s;
  logic [V-1:0]    full_nxt_s;
  logic            err_nxt_s;
  logic [PW-1:0]   route_s;
  logic            vc_ok_s;
  logic [V-1:0]    push_req_s;
  logic [V-1:0]    push_ok_s;
  logic [V-1:0]    pop_ok_s;
  logic [V-1:0]    pop_empty_s;

  // Next-state of every VC queue plus the registered output images.
  always_comb begin
    route_s     = xy_route(rq.dest_x, rq.dest_y);
    vc_ok_s     = is_onehot(rq.hdr_vc);
    mem_nxt_s   = mem_r;
    port_nxt_s  = {(V*PW){1'b0}};
    valid_nxt_s = {V{1'b0}};
    full_nxt_s  = {V{1'b0}};
    for (int i = 0; i < V; i++) begin
      push_req_s[i]  = rq.hdr_wr && vc_ok_s && rq.hdr_vc[i];
      pop_ok_s[i]    = rq.tail_sent[i] && (cnt_r[i] != CW'(0));
      pop_empty_s[i] = rq.tail_sent[i] && (cnt_r[i] == CW'(0));
      // A full queue still accepts a push when its head pops in the same cycle.
      push_ok_s[i]   = push_req_s[i] && ((cnt_r[i] != CW'(QUEUE_DEPTH)) || pop_ok_s[i]);

      if (push_ok_s[i]) begin
        mem_nxt_s[i][wr_r[i]] = route_s;
        wr_nxt_s[i]           = wr_r[i] + PTRW'(1);
      end else begin
        wr_nxt_s[i]           = wr_r[i];
      end
      rd_nxt_s[i] = pop_ok_s[i] ? (rd_r[i] + PTRW'(1)) : rd_r[i];

      case ({push_ok_s[i], pop_ok_s[i]})
        2'b10:   cnt_nxt_s[i] = cnt_r[i] + CW'(1);
        2'b01:   cnt_nxt_s[i] = cnt_r[i] - CW'(1);
        default: cnt_nxt_s[i] = cnt_r[i];
      endcase

      valid_nxt_s[i] = (cnt_nxt_s[i] != CW'(0));
      full_nxt_s[i]  = (cnt_nxt_s[i] == CW'(QUEUE_DEPTH));
      port_nxt_s[i*PW +: PW] = valid_nxt_s[i] ? mem_nxt_s[i][rd_nxt_s[i]] : {PW{1'b0}};
    end
    err_nxt_s = err_r
              | (rq.hdr_wr & ~vc_ok_s)
              | (rq.hdr_wr & out_of_range(rq.dest_x, rq.dest_y))
              | (|(push_req_s & ~push_ok_s))
              | (|pop_empty_s);
  end

  // Queue storage, pointers, counters and output registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < V; i++) begin
        for (int j = 0; j < QUEUE_DEPTH; j++) begin
          mem_r[i][j] <= {PW{1'b0}};
        end
        rd_r[i]  <= {PTRW{1'b0}};
        wr_r[i]  <= {PTRW{1'b0}};
        cnt_r[i] <= {CW{1'b0}};
      end
      port_r  <= {(V*PW){1'b0}};
      valid_r <= {V{1'b0}};
      full_r  <= {V{1'b0}};
      err_r   <= 1'b0;
    end else begin
      mem_r   <= mem_nxt_s;
      rd_r    <= rd_nxt_s;
      wr_r    <= wr_nxt_s;
      cnt_r   <= cnt_nxt_s;
      port_r  <= port_nxt_s;
      valid_r <= valid_nxt_s;
      full_r  <= full_nxt_s;
      err_r   <= err_nxt_s;
    end
  end

  assign rq.port_num_bcd = port_r;
  assign rq.route_valid  = valid_r;
  assign rq.queue_full   = full_r;
  assign rq.route_err    = err_r;

endmodule

// File: tb/tb_xy_route_queue.sv
// Bench for xy_route_queue: router at (1,1) in a 4x4 mesh, coordinate
// fields 3 bits wide so that a coordinate of 4 (outside the mesh) can be sent.
module tb_xy_route_queue;

  localparam int V  = 4;
  localparam int XW = 3;
  localparam int YW = 3;
  localparam int PW = 3;
  localparam int SX = 1;
  localparam int SY = 1;
  localparam int DEPTH = 2;

  logic clk;
  logic reset;
  int   vectors;
  int   miscompares;

  // Reference state: one queue of port numbers per VC and the sticky error.
  int   mq [V][$];
  bit   m_err;

  xy_route_queue_if #(.V(V), .XW(XW), .YW(YW), .PW(PW)) rq ();

  xy_route_queue #(
    .V(V), .X_NODE_NUM(4), .Y_NODE_NUM(4), .SW_X_ADDR(SX), .SW_Y_ADDR(SY),
    .PORT_NUM(5), .QUEUE_DEPTH(DEPTH), .XW(XW), .YW(YW), .PW(PW)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .rq    (rq.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int ref_route(input int dx, input int dy);
    if (dx >= 4 || dy >= 4) return 0;
    if (dx > SX) return 1;
    if (dx < SX) return 3;
    if (dy < SY) return 2;
    if (dy > SY) return 4;
    return 0;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    logic [V*PW-1:0] ep;
    logic [V-1:0]    ev, ef;
    ep = '0; ev = '0; ef = '0;
    for (int i = 0; i < V; i++) begin
      ev[i] = (mq[i].size() != 0);
      ef[i] = (mq[i].size() == DEPTH);
      if (mq[i].size() != 0) ep[i*PW +: PW] = PW'(mq[i][0]);
    end
    check({tag, ".port"},  32'(rq.port_num_bcd), 32'(ep));
    check({tag, ".valid"}, 32'(rq.route_valid),  32'(ev));
    check({tag, ".full"},  32'(rq.queue_full),   32'(ef));
    check({tag, ".err"},   32'(rq.route_err),    32'(m_err));
  endtask

  // One clock of stimulus: update the reference queues, clock, then compare.
  task automatic step(input string tag, input logic w, input logic [V-1:0] vc,
                      input int dx, input int dy, input logic [V-1:0] ts);
    bit popped;
    int port;
    rq.hdr_wr    = w;
    rq.hdr_vc    = vc;
    rq.dest_x    = XW'(dx);
    rq.dest_y    = YW'(dy);
    rq.tail_sent = ts;
    port = ref_route(dx, dy);
    if (w && (dx >= 4 || dy >= 4)) m_err = 1'b1;
    if (w && $countones(vc) != 1) m_err = 1'b1;
    for (int i = 0; i < V; i++) begin
      popped = 1'b0;
      if (ts[i]) begin
        if (mq[i].size() == 0) m_err = 1'b1;
        else begin
          void'(mq[i].pop_front());
          popped = 1'b1;
        end
      end
      if (w && $countones(vc) == 1 && vc[i]) begin
        if (mq[i].size() < DEPTH) mq[i].push_back(port);
        else m_err = 1'b1;
      end
      if (popped && mq[i].size() > DEPTH) m_err = 1'b1;
    end
    @(posedge clk);
    #1;
    check_all(tag);
  endtask

  task automatic idle_inputs();
    rq.hdr_wr = 1'b0; rq.hdr_vc = '0; rq.dest_x = '0; rq.dest_y = '0; rq.tail_sent = '0;
  endtask

  // Asynchronous reset applied mid-cycle; outputs must clear before the next edge.
  task automatic do_reset(input string tag);
    idle_inputs();
    #2;
    reset = 1'b0;
    for (int i = 0; i < V; i++) mq[i].delete();
    m_err = 1'b0;
    #1;
    check_all(tag);
    @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  initial begin
    logic [V-1:0] rvc, rts;
    vectors = 0;
    miscompares = 0;
    m_err = 1'b0;
    reset = 1'b0;
    idle_inputs();
    #1;
    check_all("reset_async");
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1;
    check_all("reset_state");

    // Each XY direction on VC0, replacing the head by push+pop each cycle.
    step("east",  1'b1, 4'b0001, 3, 0, 4'b0000);
    step("north", 1'b1, 4'b0001, 1, 0, 4'b0001);
    step("local", 1'b1, 4'b0001, 1, 1, 4'b0001);
    step("west",  1'b1, 4'b0001, 0, 3, 4'b0001);
    step("vc0_pop", 1'b0, 4'b0000, 0, 0, 4'b0001);

    // VC2 ordering: south then east.
    step("vc2_h1", 1'b1, 4'b0100, 1, 3, 4'b0000);
    step("vc2_h2", 1'b1, 4'b0100, 2, 1, 4'b0000);
    step("vc2_p1", 1'b0, 4'b0000, 0, 0, 4'b0100);
    step("vc2_p2", 1'b0, 4'b0000, 0, 0, 4'b0100);

    // VC1 fill, drop on full, push with pop on full.
    step("vc1_h1", 1'b1, 4'b0010, 1, 3, 4'b0000);
    step("vc1_h2", 1'b1, 4'b0010, 3, 3, 4'b0000);
    step("vc1_drop", 1'b1, 4'b0010, 1, 0, 4'b0000);
    step("vc1_pushpop", 1'b1, 4'b0010, 0, 0, 4'b0010);
    step("vc1_p1", 1'b0, 4'b0000, 0, 0, 4'b0010);
    step("vc1_p2", 1'b0, 4'b0000, 0, 0, 4'b0010);
    do_reset("rst1");

    step("pop_empty", 1'b0, 4'b0000, 0, 0, 4'b1000);
    do_reset("rst2");
    step("x_oor", 1'b1, 4'b0001, 4, 1, 4'b0000);
    do_reset("rst3");
    step("y_oor", 1'b1, 4'b0100, 2, 4, 4'b0000);
    do_reset("rst4");
    step("vc_not_onehot", 1'b1, 4'b0011, 2, 2, 4'b0000);
    do_reset("rst5");
    step("empty_pushpop", 1'b1, 4'b1000, 2, 0, 4'b1000);
    do_reset("rst6");

    // All VCs loaded, then popped in one cycle.
    for (int i = 0; i < V; i++) step("load_all", 1'b1, V'(1 << i), i, 3 - i, 4'b0000);
    step("pop_all", 1'b0, 4'b0000, 0, 0, 4'b1111);
    for (int i = 0; i < V; i++) step("reload", 1'b1, V'(1 << i), 3 - i, i, 4'b0000);
    do_reset("rst_midstream");

    // Randomized traffic with periodic resets.
    for (int n = 0; n < 400; n++) begin
      if (n % 80 == 79) do_reset("rand_rst");
      rvc = ($urandom_range(0, 7) == 0) ? V'($urandom) : V'(1 << $urandom_range(0, V - 1));
      rts = V'($urandom & $urandom);
      step("rand", 1'(($urandom_range(0, 2) != 0)), rvc,
           ($urandom_range(0, 15) == 0) ? 4 : $urandom_range(0, 3),
           ($urandom_range(0, 15) == 0) ? 4 : $urandom_range(0, 3), rts);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
